// File: rtl/sm83_pkg.sv
// sm83_pkg: shared types and constants for the SM83 interrupt controller.
//   int_state_t  - dispatch sequencer states
//   irq_idx_t    - interrupt source index
//   INT_VBLANK..INT_JOYPAD - source indices, 0 has the highest priority
//   irq_vec_t    - 16-bit dispatch vector split into hi/lo bytes
//   irq_vector() - vec(i) = base + i*stride
package sm83_pkg;

  typedef enum logic [2:0] {
    INT_IDLE,
    INT_W1,
    INT_W2,
    INT_PUSH_HI,
    INT_PUSH_LO,
    INT_JUMP
  } int_state_t;

  typedef logic [2:0] irq_idx_t;

  localparam irq_idx_t INT_VBLANK = 3'd0;
  localparam irq_idx_t INT_STAT   = 3'd1;
  localparam irq_idx_t INT_TIMER  = 3'd2;
  localparam irq_idx_t INT_SERIAL = 3'd3;
  localparam irq_idx_t INT_JOYPAD = 3'd4;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } irq_vec_t;

  function automatic irq_vec_t irq_vector(input irq_idx_t idx, input logic [15:0] base,
                                          input logic [15:0] stride);
    return irq_vec_t'(base + (16'(idx) * stride));
  endfunction

endpackage

// File: rtl/sm83_irq_prio_enc.sv
// sm83_irq_prio_enc: combinational fixed-priority encoder, lowest index wins.
// Ports:
//   req    in  NUM_IRQ  pending requests (ie & IF)
//   valid  out 1        any request pending
//   idx    out 3        index of the highest-priority pending request (0 when none)
module sm83_irq_prio_enc
  import sm83_pkg::*;
#(
  parameter int NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output irq_idx_t           idx
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = irq_idx_t'(i);
    end
  end

endmodule

// File: rtl/sm83_int_ctrl.sv
// sm83_int_ctrl: SM83 interrupt controller. Owns IF (FF0F) and IME, resolves
// pending ie&IF by fixed priority and sequences the 5-M-cycle dispatch
// (W1, W2, PUSH_HI, PUSH_LO, JUMP) executed by the core's stack/PC datapath.
// Optional feature macro: SM83_HALT_BUG_EN adds the halt_bug output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mcyc_en               M-cycle strobe gating FSM and IME updates
//   irq_in                source request lines (rising edge sets IF bit)
//   ie                    IE register (FFFF)
//   if_wr_en/if_wr_data   core write to FF0F
//   if_rd_data            {1's, IF}
//   ei, di, reti          instruction pulses (qualified by mcyc_en)
//   instr_bound           core at an opcode-fetch boundary
//   halted                core in HALT
//   wake                  |(ie & IF), independent of IME
//   disp_busy             dispatch in progress
//   push_msb/push_lsb     core pushes PC msb / lsb this M-cycle
//   pc_load, disp_vec     core loads PC with disp_vec this M-cycle
//   halt_bug (macro only) one M-cycle pulse on HALT entry with IME=0 and pending
module sm83_int_ctrl
  import sm83_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mcyc_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [7:0]         ie,
  input  logic               if_wr_en,
  input  logic [7:0]         if_wr_data,
  output logic [7:0]         if_rd_data,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               instr_bound,
  input  logic               halted,
  output logic               wake,
  output logic               disp_busy,
  output logic               push_msb,
  output logic               push_lsb,
  output logic               pc_load,
  output logic [15:0]        disp_vec
`ifdef SM83_HALT_BUG_EN
  ,
  output logic               halt_bug
`endif
);

  logic [NUM_IRQ-1:0] if_reg, if_next, irq_prev_reg, irq_edge, pend;
  logic               ime_reg, ime_next, ime_pend_reg, ime_pend_next;
  int_state_t         state_reg, state_next;
  irq_idx_t           idx_reg, enc_idx;
  logic               idx_valid_reg, enc_valid;
  logic               entry, jump_clr;
  irq_vec_t           vec;

  assign irq_edge   = irq_in & ~irq_prev_reg;
  assign pend       = ie[NUM_IRQ-1:0] & if_reg;
  assign wake       = |pend;
  assign if_rd_data = {{(8 - NUM_IRQ){1'b1}}, if_reg};

  assign entry    = mcyc_en && (state_reg == INT_IDLE) && ime_reg && instr_bound && wake;
  assign jump_clr = mcyc_en && (state_reg == INT_JUMP) && idx_valid_reg;

  // Per-bit IF update: a write overrides the held/cleared value, and a
  // request edge in the same clock beats both the write and the dispatch clear.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_if
    assign if_next[gi] = irq_edge[gi] |
                         (if_wr_en ? if_wr_data[gi]
                                   : (if_reg[gi] & ~(jump_clr && (idx_reg == irq_idx_t'(gi)))));
  end

  // EI takes effect at the instruction boundary after the one carrying it,
  // so the dispatch check at that boundary still sees the old IME.
  always_comb begin
    ime_next      = ime_reg;
    ime_pend_next = ime_pend_reg;
    if (mcyc_en) begin
      if (ime_pend_reg && instr_bound) begin
        ime_next      = 1'b1;
        ime_pend_next = 1'b0;
      end
      if (reti) ime_next = 1'b1;
      if (ei) ime_pend_next = 1'b1;
      if (di) begin
        ime_next      = 1'b0;
        ime_pend_next = 1'b0;
      end
      if (entry) ime_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    disp_busy  = 1'b0;
    push_msb   = 1'b0;
    push_lsb   = 1'b0;
    pc_load    = 1'b0;
    case (state_reg)
      INT_IDLE: if (entry) state_next = INT_W1;
      INT_W1: begin
        disp_busy = 1'b1;
        if (mcyc_en) state_next = INT_W2;
      end
      INT_W2: begin
        disp_busy = 1'b1;
        if (mcyc_en) state_next = INT_PUSH_HI;
      end
      INT_PUSH_HI: begin
        disp_busy = 1'b1;
        push_msb  = 1'b1;
        if (mcyc_en) state_next = INT_PUSH_LO;
      end
      INT_PUSH_LO: begin
        disp_busy = 1'b1;
        push_lsb  = 1'b1;
        if (mcyc_en) state_next = INT_JUMP;
      end
      INT_JUMP: begin
        disp_busy = 1'b1;
        pc_load   = 1'b1;
        if (mcyc_en) state_next = INT_IDLE;
      end
      default: state_next = INT_IDLE;
    endcase
  end

  // Priority is sampled late (during PUSH_LO) so IE/IF changes made while the
  // msb is pushed still redirect or cancel the dispatch.
  sm83_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req   (pend),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  assign vec      = irq_vector(idx_reg, VEC_BASE, 16'(VEC_STRIDE));
  assign disp_vec = ((state_reg == INT_JUMP) && idx_valid_reg) ? {vec.hi, vec.lo} : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_reg  <= '0;
      if_reg        <= '0;
      ime_reg       <= 1'b0;
      ime_pend_reg  <= 1'b0;
      state_reg     <= INT_IDLE;
      idx_reg       <= '0;
      idx_valid_reg <= 1'b0;
    end else begin
      irq_prev_reg <= irq_in;
      if_reg       <= if_next;
      ime_reg      <= ime_next;
      ime_pend_reg <= ime_pend_next;
      state_reg    <= state_next;
      if (mcyc_en && (state_reg == INT_PUSH_LO)) begin
        idx_reg       <= enc_idx;
        idx_valid_reg <= enc_valid;
      end
    end
  end

  // Upper IE/IF bits have no sources behind them.
  logic unused_bits;

`ifdef SM83_HALT_BUG_EN
  logic halted_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_prev_reg <= 1'b0;
    else if (mcyc_en) halted_prev_reg <= halted;
  end

  assign halt_bug    = halted & ~halted_prev_reg & ~ime_reg & wake;
  assign unused_bits = ^{ie[7:NUM_IRQ], if_wr_data[7:NUM_IRQ]};
`else
  assign unused_bits = ^{ie[7:NUM_IRQ], if_wr_data[7:NUM_IRQ], halted};
`endif

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// tb_sm83_int_ctrl: scoreboard bench for sm83_int_ctrl. Stimulus pushes the
// expected dispatch vector whenever it launches a dispatch; a monitor pops and
// compares on every pc_load, also checking the push/jump timing.
module tb_sm83_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mcyc_en;
  logic [4:0]  irq_in;
  logic [7:0]  ie;
  logic        if_wr_en;
  logic [7:0]  if_wr_data;
  logic [7:0]  if_rd_data;
  logic        ei, di, reti, instr_bound, halted;
  logic        wake, disp_busy, push_msb, push_lsb, pc_load;
  logic [15:0] disp_vec;
`ifdef SM83_HALT_BUG_EN
  logic        halt_bug;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  int   mon_t      = 0;
  int   t_rise     = -100;
  int   t_msb      = -100;
  int   t_lsb      = -100;
  logic prev_busy  = 1'b0;
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  sm83_int_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mcyc_en     (mcyc_en),
    .irq_in      (irq_in),
    .ie          (ie),
    .if_wr_en    (if_wr_en),
    .if_wr_data  (if_wr_data),
    .if_rd_data  (if_rd_data),
    .ei          (ei),
    .di          (di),
    .reti        (reti),
    .instr_bound (instr_bound),
    .halted      (halted),
    .wake        (wake),
    .disp_busy   (disp_busy),
    .push_msb    (push_msb),
    .push_lsb    (push_lsb),
    .pc_load     (pc_load),
    .disp_vec    (disp_vec)
`ifdef SM83_HALT_BUG_EN
    ,
    .halt_bug    (halt_bug)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_if(input logic [7:0] d);
    if_wr_en = 1'b1; if_wr_data = d; cyc(); if_wr_en = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1; cyc(); reti = 1'b0;
  endtask

  task automatic do_ei();
    ei = 1'b1; cyc(); ei = 1'b0;
  endtask

  task automatic do_di();
    di = 1'b1; cyc(); di = 1'b0;
  endtask

  task automatic bound();
    instr_bound = 1'b1; cyc(); instr_bound = 1'b0;
  endtask

  // Monitor: one transaction line per dispatch.
  initial begin
    forever begin
      @(negedge clk);
      mon_t++;
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (disp_busy && !prev_busy) t_rise = mon_t;
        if (push_msb) t_msb = mon_t;
        if (push_lsb) t_lsb = mon_t;
        if (pc_load) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_dispatch: got pc_load=1 disp_vec=%h, required no dispatch", disp_vec);
          end else begin
            mon_exp = exp_q.pop_front();
            $display("dispatch: disp_vec=%h expected=%h", disp_vec, mon_exp);
            chk("disp_vec", disp_vec, mon_exp);
            chk("busy_to_pc_load", 16'(mon_t - t_rise), 16'd4);
            chk("msb_to_pc_load", 16'(mon_t - t_msb), 16'd2);
            chk("lsb_to_pc_load", 16'(mon_t - t_lsb), 16'd1);
          end
        end
        prev_busy = disp_busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mcyc_en = 1'b1; irq_in = '0; ie = 8'h00; if_wr_en = 1'b0; if_wr_data = 8'h00;
    ei = 1'b0; di = 1'b0; reti = 1'b0; instr_bound = 1'b0; halted = 1'b0;
    repeat (3) cyc();
    chk("rst_if_rd", {8'h00, if_rd_data}, 16'h00E0);
    chk("rst_wake", {15'd0, wake}, 16'd0);
    chk("rst_busy", {15'd0, disp_busy}, 16'd0);
    chk("rst_push", {14'd0, push_msb, push_lsb}, 16'd0);
    chk("rst_pc_load", {15'd0, pc_load}, 16'd0);
    chk("rst_disp_vec", disp_vec, 16'h0000);
    rst_n = 1'b1;
    cyc();

    // mcyc_en low: RETI must not enable IME, so no dispatch.
    ie = 8'h1F;
    mcyc_en = 1'b0; do_reti(); mcyc_en = 1'b1;
    wr_if(8'h04);
    bound();
    chk("mcyc_gate_no_disp", {15'd0, disp_busy}, 16'd0);
    wr_if(8'h00);

    // Test 1: TIMER dispatch, then IME must be cleared.
    do_reti();
    irq_in[2] = 1'b1; cyc();
    chk("t1_if_set", {8'h00, if_rd_data}, 16'h00E4);
    exp_q.push_back(16'h0050);
    bound();
    chk("t1_busy_after_bound", {15'd0, disp_busy}, 16'd1);
    repeat (6) cyc();
    chk("t1_if_cleared", {8'h00, if_rd_data}, 16'h00E0);
    wr_if(8'h04);
    bound();
    chk("t1_ime_cleared", {15'd0, disp_busy}, 16'd0);
    wr_if(8'h00);

    // Test 2: VBLANK before TIMER.
    ie = 8'h05;
    wr_if(8'h05);
    do_reti();
    exp_q.push_back(16'h0040);
    bound();
    repeat (6) cyc();
    chk("t2_if_after_first", {8'h00, if_rd_data}, 16'h00E4);
    do_reti();
    exp_q.push_back(16'h0050);
    bound();
    repeat (6) cyc();
    chk("t2_if_after_second", {8'h00, if_rd_data}, 16'h00E0);

    // Test 3: EI delay, then EI;DI.
    ie = 8'h1F;
    wr_if(8'h04);
    do_ei();
    bound();
    chk("t3_ei_delay", {15'd0, disp_busy}, 16'd0);
    exp_q.push_back(16'h0050);
    bound();
    chk("t3_ei_dispatch", {15'd0, disp_busy}, 16'd1);
    repeat (6) cyc();
    wr_if(8'h04);
    do_ei();
    do_di();
    bound();
    chk("t3_eidi_bound1", {15'd0, disp_busy}, 16'd0);
    bound();
    chk("t3_eidi_bound2", {15'd0, disp_busy}, 16'd0);
    repeat (2) cyc();
    chk("t3_eidi_if", {8'h00, if_rd_data}, 16'h00E4);

    // Test 4: IE cleared during PUSH_HI cancels the dispatch.
    do_reti();
    exp_q.push_back(16'h0000);
    bound();
    for (int k = 0; k < 10 && !push_msb; k++) cyc();
    chk("t4_reach_push_hi", {15'd0, push_msb}, 16'd1);
    ie = 8'h00;
    repeat (6) cyc();
    chk("t4_if_unchanged", {8'h00, if_rd_data}, 16'h00E4);
    ie = 8'h1F;
    wr_if(8'h00);

    // Test 5: HALT wake with IME=0.
    ie = 8'h10; halted = 1'b1;
    cyc();
    chk("t5_wake_before", {15'd0, wake}, 16'd0);
    irq_in[4] = 1'b1; cyc();
    chk("t5_wake", {15'd0, wake}, 16'd1);
    bound();
    chk("t5_no_disp", {15'd0, disp_busy}, 16'd0);
    halted = 1'b0; irq_in[4] = 1'b0;
    wr_if(8'h00);
`ifdef SM83_HALT_BUG_EN
    wr_if(8'h10);
    cyc();
    halted = 1'b1; #1;
    chk("t5_halt_bug_pulse", {15'd0, halt_bug}, 16'd1);
    cyc();
    chk("t5_halt_bug_end", {15'd0, halt_bug}, 16'd0);
    halted = 1'b0;
    wr_if(8'h00);
`endif

    // Test 6: edge beats a same-cycle write; reset mid-PUSH_LO.
    ie = 8'h1F;
    wr_if(8'h03);
    chk("t6_if_preset", {8'h00, if_rd_data}, 16'h00E3);
    if_wr_en = 1'b1; if_wr_data = 8'h00; irq_in[1] = 1'b1;
    cyc();
    if_wr_en = 1'b0;
    chk("t6_edge_wins", {8'h00, if_rd_data}, 16'h00E2);
    do_reti();
    bound();
    for (int k = 0; k < 10 && !push_lsb; k++) cyc();
    chk("t6_reach_push_lo", {15'd0, push_lsb}, 16'd1);
    rst_n = 1'b0; irq_in = '0;
    #1;
    chk("t6_rst_busy", {15'd0, disp_busy}, 16'd0);
    chk("t6_rst_push", {14'd0, push_msb, push_lsb}, 16'd0);
    chk("t6_rst_pc_load", {15'd0, pc_load}, 16'd0);
    chk("t6_rst_disp_vec", disp_vec, 16'h0000);
    chk("t6_rst_if", {8'h00, if_rd_data}, 16'h00E0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
